md5_block_padder: RTL and testbench

Turns each candidate phrase from the phrase generator into one fully padded 512-bit MD5 message block and feeds it to the MD5 core. It applies the standard MD5 padding: message bytes, then 0x80, then zero fill, then the 64-bit little-endian bit length. It buffers up to two finished blocks behind a valid/ready handshake and tags each block with a sequence number. Phrases too long for a single block are dropped and flagged.

---
 rtl/md5_block_padder.sv | 162 ++++++++++++++++
 tb/tb_md5_block_padder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_block_padder.sv
// md5_block_padder
//
// Pads each accepted phrase into one 512-bit MD5 message block. The layout is
// the message bytes, then 0x80, then zero fill, then the 64-bit little-endian
// bit length. Finished blocks are held in a two-entry FIFO along with a
// sequence tag. Phrases longer than MAX_LEN bytes are consumed, dropped and
// counted.
//
// Ports
//   clk         sole clock, posedge
//   rst         asynchronous active-high reset
//   flush       synchronous clear of FIFO, sequence counter and error state
//   in_valid    phrase presented
//   in_ready    padder can accept (FIFO count < 2), driven from a register
//   in_msg      phrase bytes, byte k at [8k+7:8k]
//   in_len      phrase length in bytes
//   out_valid   block available at FIFO head
//   out_ready   MD5 core takes the head block
//   out_block   padded block at FIFO head, byte k at [8k+7:8k]
//   out_seq     sequence tag of the head block
//   err         sticky drop flag
//   drop_count  saturating count of dropped phrases
module md5_block_padder #(
  parameter int MAX_LEN = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [447:0] in_msg,
  input  logic [7:0]   in_len,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic [31:0]  out_seq,
  output logic         err,
  output logic [15:0]  drop_count
);

  // Build the padded block. Bytes at or beyond len are masked, never copied.
  function automatic logic [511:0] pad_block(input logic [447:0] msg,
                                             input logic [7:0]   len);
    logic [511:0] blk;
    logic [15:0]  bits;
    blk = 512'd0;
    for (int k = 0; k < 56; k++) begin
      if (k < int'(len)) begin
        blk[8*k +: 8] = msg[8*k +: 8];
      end else if (k == int'(len)) begin
        blk[8*k +: 8] = 8'h80;
      end else begin
        blk[8*k +: 8] = 8'h00;
      end
    end
    // Bit length fits in 16 bits; bytes 58..63 stay zero.
    bits = {5'd0, len, 3'd0};
    blk[455:448] = bits[7:0];
    blk[463:456] = bits[15:8];
    return blk;
  endfunction

  // Head entry drives the outputs directly; tail holds the second entry.
  logic [511:0] head_blk_r, tail_blk_r;
  logic [31:0]  head_seq_r, tail_seq_r;
  logic [1:0]   count_r;
  logic [31:0]  seq_next_r;
  logic         in_ready_r, out_valid_r, err_r;
  logic [15:0]  drop_count_r;

  logic         accept_s, oversize_s, push_s, pop_s, drop_s;
  logic [1:0]   count_nxt_s;
  logic [511:0] pad_s;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_block  = head_blk_r;
  assign out_seq    = head_seq_r;
  assign err        = err_r;
  assign drop_count = drop_count_r;

  // Handshake decode, padding and next FIFO occupancy.
  always_comb begin
    accept_s    = in_valid && in_ready_r;
    oversize_s  = (int'(in_len) > MAX_LEN);
    push_s      = accept_s && !oversize_s;
    drop_s      = accept_s && oversize_s;
    pop_s       = out_valid_r && out_ready;
    pad_s       = pad_block(in_msg, in_len);
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, occupancy flags, sequence counter and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_blk_r   <= 512'd0;
      tail_blk_r   <= 512'd0;
      head_seq_r   <= 32'd0;
      tail_seq_r   <= 32'd0;
      count_r      <= 2'd0;
      seq_next_r   <= 32'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      err_r        <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (flush) begin
      // Flush beats any push or pop presented in the same cycle.
      count_r      <= 2'd0;
      seq_next_r   <= 32'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      err_r        <= 1'b0;
      drop_count_r <= 16'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_blk_r <= pad_s;
            head_seq_r <= seq_next_r;
          end
        end
        2'd1: begin
          // Push with pop at one entry replaces the head in place.
          if (push_s && pop_s) begin
            head_blk_r <= pad_s;
            head_seq_r <= seq_next_r;
          end else if (push_s) begin
            tail_blk_r <= pad_s;
            tail_seq_r <= seq_next_r;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_blk_r <= tail_blk_r;
            head_seq_r <= tail_seq_r;
          end
        end
        default: begin
          head_blk_r <= head_blk_r;
        end
      endcase
      if (push_s) begin
        seq_next_r <= seq_next_r + 32'd1;
      end
      if (drop_s) begin
        err_r <= 1'b1;
        if (drop_count_r != 16'hFFFF) begin
          drop_count_r <= drop_count_r + 16'd1;
        end
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
    end
  end

endmodule

// File: tb/tb_md5_block_padder.sv
module tb_md5_block_padder;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic         in_ready, out_valid, err;
  logic [447:0] in_msg;
  logic [7:0]   in_len;
  logic [511:0] out_block;
  logic [31:0]  out_seq;
  logic [15:0]  drop_count;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [543:0] sb_q[$];
  logic [31:0]  exp_seq;
  logic         exp_err;
  logic [15:0]  exp_drop;

  always #5 clk = ~clk;

  md5_block_padder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_seq(out_seq), .err(err), .drop_count(drop_count)
  );

  // Reference padding built byte by byte from a zeroed block.
  function automatic logic [511:0] model_pad(input logic [447:0] m, input logic [7:0] l);
    logic [511:0] b;
    int bits;
    b = 512'd0;
    for (int i = 0; i < int'(l); i++) b[8*i +: 8] = m[8*i +: 8];
    b[8*int'(l) +: 8] = 8'h80;
    bits = int'(l) * 8;
    b[455:448] = bits[7:0];
    b[463:456] = bits[15:8];
    return b;
  endfunction

  function automatic logic [447:0] rand_msg();
    logic [447:0] m;
    for (int i = 0; i < 14; i++) m[32*i +: 32] = $urandom();
    return m;
  endfunction

  // One clock: drive, let the scoreboard observe mid-cycle, then compare
  // status outputs against the model just after the edge.
  task automatic cycle(input logic v, input logic [447:0] m, input logic [7:0] l,
                       input logic ordy, input logic fl);
    logic [543:0] e;
    in_valid = v; in_msg = m; in_len = l; out_ready = ordy; flush = fl;
    @(negedge clk);
    if (fl) begin
      sb_q.delete();
      exp_seq = 32'd0; exp_err = 1'b0; exp_drop = 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_pop: unexpected block seq=%h with empty scoreboard", out_seq);
        end else begin
          e = sb_q.pop_front();
          if ({out_block, out_seq} !== e) begin
            failures++;
            $display("FAIL sb_block: got seq=%h blk=%h expected seq=%h blk=%h",
                     out_seq, out_block, e[31:0], e[543:32]);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (l > 8'd55) begin
          exp_err = 1'b1;
          if (exp_drop != 16'hFFFF) exp_drop++;
        end else begin
          sb_q.push_back({model_pad(m, l), exp_seq});
          exp_seq++;
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, err, drop_count} !==
        {sb_q.size() != 0, sb_q.size() < 2, exp_err, exp_drop}) begin
      failures++;
      $display("FAIL status: got valid=%b ready=%b err=%b drop=%0d expected valid=%b ready=%b err=%b drop=%0d",
               out_valid, in_ready, err, drop_count, sb_q.size() != 0, sb_q.size() < 2, exp_err, exp_drop);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 448'd0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d blocks left, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, in_ready, err, drop_count, out_seq} !== {1'b0, 1'b1, 1'b0, 16'd0, 32'd0}
        || out_block !== 512'd0) begin
      failures++;
      $display("FAIL reset: got valid=%b ready=%b err=%b drop=%0d seq=%h expected 0 1 0 0 0",
               out_valid, in_ready, err, drop_count, out_seq);
    end
  endtask

  task automatic test_abc();
    logic [447:0] m;
    logic [479:0] upper;
    m = rand_msg();
    m[23:0] = 24'h636261;
    upper = {48'd0, 8'h00, 8'h18, 416'd0};
    cycle(1'b1, m, 8'd3, 1'b0, 1'b0);
    checks++;
    if (out_block[31:0] !== 32'h80636261 || out_block[511:32] !== upper ||
        out_seq !== 32'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abc: got valid=%b seq=%h blk=%h expected valid=1 seq=0 low=80636261 byte56=18",
               out_valid, out_seq, out_block);
    end
    drain();
  endtask

  task automatic test_lengths();
    cycle(1'b1, 448'd0, 8'd0, 1'b1, 1'b1);
    cycle(1'b1, rand_msg(), 8'd0, 1'b0, 1'b0);
    checks++;
    if (out_block !== {504'd0, 8'h80}) begin
      failures++;
      $display("FAIL len0: got %h expected only byte0=80", out_block);
    end
    cycle(1'b1, rand_msg(), 8'd55, 1'b1, 1'b0);
    checks++;
    if ({out_block[463:456], out_block[455:448], out_block[447:440], out_seq} !==
        {8'h01, 8'hB8, 8'h80, 32'd1}) begin
      failures++;
      $display("FAIL len55: got b57=%h b56=%h b55=%h seq=%h expected 01 B8 80 1",
               out_block[463:456], out_block[455:448], out_block[447:440], out_seq);
    end
    drain();
  endtask

  task automatic test_oversize();
    cycle(1'b0, 448'd0, 8'd0, 1'b1, 1'b1);
    cycle(1'b1, rand_msg(), 8'd56, 1'b0, 1'b0);
    checks++;
    if ({out_valid, err, drop_count} !== {1'b0, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL oversize: got valid=%b err=%b drop=%0d expected 0 1 1", out_valid, err, drop_count);
    end
    cycle(1'b1, rand_msg(), 8'd5, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_seq} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL oversize_next: got valid=%b seq=%h expected 1 0", out_valid, out_seq);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [447:0] m3;
    m3 = rand_msg();
    cycle(1'b0, 448'd0, 8'd0, 1'b0, 1'b1);
    pops = 0;
    cycle(1'b1, rand_msg(), 8'd10, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd20, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready: got in_ready=%b expected 0", in_ready);
    end
    cycle(1'b1, m3, 8'd30, 1'b0, 1'b0);
    cycle(1'b1, m3, 8'd30, 1'b1, 1'b0);
    cycle(1'b1, m3, 8'd30, 1'b1, 1'b0);
    drain();
    checks++;
    if (pops != 3) begin
      failures++;
      $display("FAIL bp_count: got %0d blocks expected 3", pops);
    end
  endtask

  task automatic test_back_to_back_wrap();
    cycle(1'b0, 448'd0, 8'd0, 1'b1, 1'b1);
    force dut.seq_next_r = 32'hFFFFFFFF;
    #1 release dut.seq_next_r;
    exp_seq = 32'hFFFFFFFF;
    pops = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, rand_msg(), 8'($urandom_range(0, 55)), 1'b1, 1'b0);
    checks++;
    if (pops != 5) begin
      failures++;
      $display("FAIL stream_rate: got %0d blocks in 6 cycles expected 5", pops);
    end
    drain();
  endtask

  task automatic test_flush();
    cycle(1'b1, rand_msg(), 8'd60, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd1, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd2, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd3, 1'b0, 1'b1);
    checks++;
    if ({out_valid, in_ready, err, drop_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL flush: got valid=%b ready=%b err=%b drop=%0d expected 0 1 0 0",
               out_valid, in_ready, err, drop_count);
    end
    cycle(1'b1, rand_msg(), 8'd4, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd4, 1'b0, 1'b1);
    cycle(1'b1, rand_msg(), 8'd7, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_seq} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL flush_seq: got valid=%b seq=%h expected 1 0", out_valid, out_seq);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, rand_msg(), 8'd99, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd9, 1'b0, 1'b0);
    cycle(1'b1, rand_msg(), 8'd8, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, err, drop_count, out_seq} !== {1'b0, 1'b1, 1'b0, 16'd0, 32'd0}
        || out_block !== 512'd0) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b ready=%b err=%b drop=%0d seq=%h expected 0 1 0 0 0",
               out_valid, in_ready, err, drop_count, out_seq);
    end
    sb_q.delete();
    exp_seq = 32'd0; exp_err = 1'b0; exp_drop = 16'd0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, rand_msg(), 8'd12, 1'b0, 1'b0);
    checks++;
    if (out_seq !== 32'd0) begin
      failures++;
      $display("FAIL reset_seq: got seq=%h expected 0", out_seq);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_msg = 448'd0; in_len = 8'd0;
    exp_seq = 32'd0; exp_err = 1'b0; exp_drop = 16'd0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_abc();
    test_lengths();
    test_oversize();
    test_backpressure();
    test_back_to_back_wrap();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
